// File: rtl/memory_dump_reader_pkg.sv
// Shared constants and types for the stack-memory dump reader.
// Holds the dump-port defaults, the port direction encodings and the controller state type.
package memory_dump_reader_pkg;

  // Default dump-port geometry
  localparam int ADDRESS_BITS = 8;
  localparam int DATA_BITS    = 16;

  // Dump-port read/write mode encodings
  localparam logic RAM_READ  = 1'b0;
  localparam logic RAM_WRITE = 1'b1;

  // Sweep controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HOLD   = 3'd3,
    ST_FINISH = 3'd4
  } dump_state_e;

endpackage : memory_dump_reader_pkg

// File: rtl/memory_dump_reader.sv
// Dump-port master: sweeps a contiguous address window on start and
// streams every captured word out on a valid/ready interface.
// One word takes three cycles: present address, take read data, hand off.
module memory_dump_reader
  import memory_dump_reader_pkg::*;
#(
  parameter int addrBits = ADDRESS_BITS,
  parameter int dataBits = DATA_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addrBits-1:0] baseAddress,
  input  logic [addrBits:0]   wordCount,
  output logic                busy,
  output logic                done,
  output logic [addrBits-1:0] memAddress,
  output logic                memReadWriteMode,
  output logic [dataBits-1:0] memDataIn,
  input  logic [dataBits-1:0] memDataOut,
  output logic [dataBits-1:0] outData,
  output logic                outValid,
  output logic                outLast,
  input  logic                outReady
);

  localparam logic [addrBits:0]   REMAIN_ONE = {{addrBits{1'b0}}, 1'b1};
  localparam logic [addrBits-1:0] ADDR_STEP  = {{(addrBits-1){1'b0}}, 1'b1};

  dump_state_e         state_q, state_d;
  logic [addrBits-1:0] mem_address_q, mem_address_d;
  logic [addrBits:0]   remaining_q, remaining_d;
  logic [dataBits-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // True when the word in flight is the final one of the window
  function automatic logic is_final_word(input logic [addrBits:0] remaining);
    return remaining == REMAIN_ONE;
  endfunction

  // Next-state and next-output computation for the sweep controller
  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    remaining_d   = remaining_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (wordCount != '0) begin
            remaining_d   = wordCount;
            mem_address_d = baseAddress;
            busy_d        = 1'b1;
            state_d       = ST_ISSUE;
          end else begin
            // Empty window: report completion without touching memory
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end
        end
      end

      ST_ISSUE: begin
        // Memory samples memAddress at this edge; data appears next cycle
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        out_data_d  = memDataOut;
        out_valid_d = 1'b1;
        out_last_d  = is_final_word(remaining_q);
        state_d     = ST_HOLD;
      end

      ST_HOLD: begin
        if (outReady) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (is_final_word(remaining_q)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            // Address wraps naturally at 2^addrBits
            remaining_d   = remaining_q - REMAIN_ONE;
            mem_address_d = mem_address_q + ADDR_STEP;
            state_d       = ST_ISSUE;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All controller state and registered outputs; reset clears everything at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mem_address_q <= '0;
      remaining_q   <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      remaining_q   <= remaining_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // This block only ever reads the dump port
  assign memReadWriteMode = RAM_READ;
  assign memDataIn        = '0;

  assign memAddress = mem_address_q;
  assign outData    = out_data_q;
  assign outValid   = out_valid_q;
  assign outLast    = out_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule : memory_dump_reader
